// File: rtl/mul_mc.sv
// Multicycle shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional early exit on exhausted multiplier: define MUL_EARLY_EXIT_EN.
module mul_mc #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    input  logic [DATA_WIDTH-1:0] multiplier,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ready,
    output logic                  busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic            neg_q;
    logic [W-1:0]    mcand;
    logic [W-1:0]    mplr;
    logic [2*W-1:0]  prod;
    logic [CW-1:0]   count;

    logic            s1;
    logic            s2;
    logic            neg1;
    logic            neg2;
    logic [W-1:0]    abs1;
    logic [W-1:0]    abs2;
    logic            accept;
    logic            zero_op;
    logic [W:0]      sum;
    logic [2*W-1:0]  step_prod;
    logic [W-1:0]    mplr_nx;
    logic            last;
    logic [2*W-1:0]  fin_prod;
    logic [2*W-1:0]  signed_p;

    assign s1      = (op == 2'b01) || (op == 2'b10);
    assign s2      = (op == 2'b01);
    assign neg1    = s1 & multiplicand[W-1];
    assign neg2    = s2 & multiplier[W-1];
    assign abs1    = neg1 ? -multiplicand : multiplicand;
    assign abs2    = neg2 ? -multiplier : multiplier;
    assign accept  = start && !busy;
    assign zero_op = (multiplicand == '0) || (multiplier == '0);

    // The adder carry becomes the top bit of the shifted product.
    assign sum       = {1'b0, prod[2*W-1:W]} + {1'b0, (mplr[0] ? mcand : '0)};
    assign step_prod = {sum, prod[W-1:1]};
    assign mplr_nx   = mplr >> 1;

`ifdef MUL_EARLY_EXIT_EN
    assign last     = (count == CW'(W-1)) || (mplr_nx == '0);
    // count holds the index of the final step; finish the skipped shifts.
    assign fin_prod = prod >> (CW'(W-1) - count);
`else
    assign last     = (count == CW'(W-1));
    assign fin_prod = prod;
`endif

    assign signed_p = neg_q ? -fin_prod : fin_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            neg_q  <= 1'b0;
            mcand  <= '0;
            mplr   <= '0;
            prod   <= '0;
            count  <= '0;
            result <= '0;
            ready  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        neg_q <= neg1 ^ neg2;
                        mcand <= abs1;
                        mplr  <= abs2;
                        if (zero_op) begin
                            result <= '0;
                            ready  <= 1'b1;
                        end else begin
                            ready <= 1'b0;
                            busy  <= 1'b1;
                            prod  <= '0;
                            count <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prod <= step_prod;
                    mplr <= mplr_nx;
                    if (last) begin
                        state <= FIN;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                FIN: begin
                    result <= (op_q == 2'b00) ? signed_p[W-1:0]
                                              : signed_p[2*W-1:W];
                    ready  <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
